// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan controller with a frame-synchronised load/ready handshake.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
  parameter int PRESCALE = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [3:0]  blank_mask,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   display_q, display_d;
  logic          ready_q, ready_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_bnd;
  logic          blank_sel;
  logic [3:0]    nib [4];
  logic [3:0]    lz_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan timing and handshake; a capture on a boundary cycle leaves the value pending.
  always_comb begin
    slot_end  = (presc_q == LAST);
    frame_bnd = slot_end && (idx_q == 2'd3);
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    ready_d   = ready_q;
    if (load && ready_q) begin
      shadow_d = value_in;
      ready_d  = 1'b0;
    end else if (frame_bnd && !ready_q) begin
      display_d = shadow_q;
      ready_d   = 1'b1;
    end
    frame_done_d = frame_bnd;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi] = display_d[gi*4 +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = (display_d[15:gi*4] == '0);
      end
`else
      assign lz_blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Outputs are registered from the post-increment index and post-commit value.
  always_comb begin
    blank_sel = blank_mask[idx_d] | lz_blank[idx_d];
    anode_d   = 4'hF;
    cathode_d = 7'h7F;
    if (!blank_sel) begin
      anode_d   = ~(4'b0001 << idx_d);
      cathode_d = glyph(nib[idx_d]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      display_q    <= 16'h0000;
      ready_q      <= 1'b1;
      anode_q      <= 4'hF;
      cathode_q    <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      ready_q      <= ready_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = ready_q;
  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
